efuse_reader: RTL and testbench

- Read-side counterpart of the eFuse programming controller.
- On a start request in read mode, asserts CSB, generates NBITS SCLK pulses with PGM held low, and shifts the eFuse serial output Q into a parallel word.
- Flags completion with data_valid.
- Sits beside the programming state machine on the divided clk_8M domain and feeds the readback register.

---
 rtl/efuse_reader.sv | 149 ++++++++++++++
 tb/tb_efuse_reader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/efuse_reader.sv
// eFuse read sequencer: drives CSB/SCLK with PGM held low and shifts Q into a parallel word.
module efuse_reader #(
  parameter int unsigned NBITS = 32,
  parameter int unsigned TCSS  = 2,
  parameter int unsigned THOLD = 2
) (
  input  logic             clk_8M,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [3:0]       TCKHP,
  input  logic             Q,
  output logic             CSB,
  output logic             PGM,
  output logic             SCLK,
  output logic             busy,
  output logic             data_valid,
  output logic [NBITS-1:0] data_out
);

  localparam int unsigned CW = 4;
  localparam int unsigned BW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [1:0]    MODE_READ = 2'b10;
  localparam logic [CW-1:0] TCSS_LAST = CW'(TCSS - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(THOLD - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SCLK_HI,
    SCLK_LO,
    CS_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     tck_q, tck_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              start_q;
  logic              csb_d, sclk_d, busy_d, dv_d;
  logic [NBITS-1:0]  data_d;
  logic              start_edge_c;
  logic [CW-1:0]     tck_last_c;

  assign start_edge_c = start & ~start_q;
  assign tck_last_c   = tck_q - CW'(1);
  assign PGM          = 1'b0;

  // State, counters and registered eFuse-side outputs.
  always_ff @(posedge clk_8M or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tck_q      <= '0;
      bit_q      <= '0;
      start_q    <= 1'b0;
      CSB        <= 1'b1;
      SCLK       <= 1'b0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tck_q      <= tck_d;
      bit_q      <= bit_d;
      start_q    <= start;
      CSB        <= csb_d;
      SCLK       <= sclk_d;
      busy       <= busy_d;
      data_valid <= dv_d;
      data_out   <= data_d;
    end
  end

  // Next-state and next-output logic for the read sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tck_d   = tck_q;
    bit_d   = bit_q;
    csb_d   = CSB;
    sclk_d  = SCLK;
    busy_d  = busy;
    dv_d    = data_valid;
    data_d  = data_out;
    case (state_q)
      IDLE: begin
        if (start_edge_c && (mode == MODE_READ)) begin
          state_d = CS_SETUP;
          cnt_d   = '0;
          bit_d   = '0;
          tck_d   = (TCKHP == 4'd0) ? CW'(1) : TCKHP;
          csb_d   = 1'b0;
          busy_d  = 1'b1;
          dv_d    = 1'b0;
        end
      end
      CS_SETUP: begin
        if (cnt_q == TCSS_LAST) begin
          state_d = SCLK_HI;
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SCLK_HI: begin
        if (cnt_q == tck_last_c) begin
          data_d[bit_q] = Q;
          sclk_d        = 1'b0;
          state_d       = SCLK_LO;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SCLK_LO: begin
        if (cnt_q == tck_last_c) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = CS_HOLD;
          end else begin
            bit_d   = bit_q + BW'(1);
            sclk_d  = 1'b1;
            state_d = SCLK_HI;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CS_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          csb_d   = 1'b1;
          busy_d  = 1'b0;
          dv_d    = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_efuse_reader.sv
// Self-checking bench for efuse_reader: fuse-array model on Q, waveform monitor, latency/data model.
module tb_efuse_reader;

  localparam int unsigned NBITS = 32;
  localparam int unsigned TCSS  = 2;
  localparam int unsigned THOLD = 2;

  logic             clk_8M;
  logic             rst;
  logic [1:0]       mode;
  logic             start;
  logic [3:0]       TCKHP;
  logic             Q;
  logic             CSB, PGM, SCLK, busy, data_valid;
  logic [NBITS-1:0] data_out;

  int checks;
  int errors;

  logic [31:0] q_pat;
  int          q_idx;
  int          exp_t;
  int          pulses, width_bad, csb_bad, pgm_bad;
  int          hi_run, lo_run;
  logic        prev_sclk;

  efuse_reader #(.NBITS(NBITS), .TCSS(TCSS), .THOLD(THOLD)) dut (
    .clk_8M(clk_8M), .rst(rst), .mode(mode), .start(start), .TCKHP(TCKHP), .Q(Q),
    .CSB(CSB), .PGM(PGM), .SCLK(SCLK), .busy(busy), .data_valid(data_valid),
    .data_out(data_out)
  );

  initial clk_8M = 1'b0;
  always #5 clk_8M = ~clk_8M;

  // Fuse array model: presents the next pattern bit (LSB first) on each SCLK rise.
  always @(posedge SCLK) begin
    if (q_idx < 32) Q = q_pat[q_idx];
    q_idx++;
  end

  // Waveform monitor: SCLK phase widths, CSB framing, PGM level.
  always @(negedge clk_8M) begin
    if (PGM !== 1'b0) pgm_bad++;
    if (busy && CSB !== 1'b0) csb_bad++;
    if (SCLK && CSB) csb_bad++;
    if (SCLK !== prev_sclk) begin
      if (prev_sclk) begin
        if (hi_run != exp_t) width_bad++;
      end else if (pulses > 0) begin
        if (lo_run != exp_t) width_bad++;
      end
      if (SCLK) pulses++;
      hi_run = 0;
      lo_run = 0;
    end
    if (SCLK) hi_run++; else lo_run++;
    prev_sclk = SCLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One read through the model; hold_start keeps start high and re-toggles it mid-read.
  task automatic do_read(input logic [31:0] pat, input logic [3:0] tck, input bit hold_start,
                         input string tag);
    int eff, lat, n;
    bit done;
    eff = (tck == 4'd0) ? 1 : int'(tck);
    lat = int'(TCSS) + 2 * eff * int'(NBITS) + int'(THOLD);
    @(negedge clk_8M);
    start = 1'b0;
    @(negedge clk_8M);
    mode  = 2'b10;
    TCKHP = tck;
    q_pat = pat;
    q_idx = 0;
    start = 1'b1;
    @(posedge clk_8M);
    exp_t = eff; pulses = 0; width_bad = 0; csb_bad = 0; pgm_bad = 0;
    #1;
    TCKHP = 4'($urandom);
    mode  = 2'($urandom);
    n = 0;
    done = 1'b0;
    while (!done && n < 2000) begin
      @(negedge clk_8M);
      n++;
      if (n == 1) begin
        chk({tag, "_busy_e0"}, 32'(busy), 1);
        chk({tag, "_csb_e0"}, 32'(CSB), 0);
        chk({tag, "_dv_e0"}, 32'(data_valid), 0);
        if (!hold_start) start = 1'b0;
      end
      if (hold_start && n == 100) start = 1'b0;
      if (hold_start && n == 101) start = 1'b1;
      if (data_valid) done = 1'b1;
    end
    chk({tag, "_latency"}, 32'(n - 1), 32'(lat));
    chk({tag, "_data"}, data_out, pat);
    chk({tag, "_pulses"}, 32'(pulses), NBITS);
    chk({tag, "_width_bad"}, 32'(width_bad), 0);
    chk({tag, "_csb_bad"}, 32'(csb_bad), 0);
    chk({tag, "_pgm_bad"}, 32'(pgm_bad), 0);
    chk({tag, "_csb_end"}, 32'(CSB), 1);
    chk({tag, "_busy_end"}, 32'(busy), 0);
  endtask

  initial begin
    int bad, n;
    logic [1:0] gate_modes [2];
    checks = 0; errors = 0;
    q_pat = '0; q_idx = 0; exp_t = 1;
    pulses = 0; width_bad = 0; csb_bad = 0; pgm_bad = 0;
    hi_run = 0; lo_run = 0; prev_sclk = 1'b0;
    mode = 2'b00; start = 1'b0; TCKHP = 4'd4; Q = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_csb", 32'(CSB), 1);
    chk("rst_sclk", 32'(SCLK), 0);
    chk("rst_pgm", 32'(PGM), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dv", 32'(data_valid), 0);
    chk("rst_data", data_out, 0);
    repeat (3) @(negedge clk_8M);
    rst = 1'b1;

    do_read(32'hA5C30F96, 4'd4, 1'b0, "basic");
    do_read(32'hFFFFFFFF, 4'd0, 1'b0, "tck0");

    // Starts in non-read modes must be ignored.
    gate_modes[0] = 2'b01;
    gate_modes[1] = 2'b00;
    foreach (gate_modes[i]) begin
      @(negedge clk_8M);
      mode = gate_modes[i];
      start = 1'b0;
      @(negedge clk_8M) start = 1'b1;
      @(negedge clk_8M) start = 1'b0;
      bad = 0;
      repeat (20) begin
        @(negedge clk_8M);
        if (CSB !== 1'b1 || SCLK !== 1'b0 || busy !== 1'b0) bad++;
      end
      chk("gate_idle", 32'(bad), 0);
    end
    do_read($urandom, 4'd4, 1'b0, "post_gate");

    // Start held high, plus an edge while busy: exactly one read.
    do_read($urandom, 4'd3, 1'b1, "hold");
    bad = 0;
    repeat (20) begin
      @(negedge clk_8M);
      if (busy !== 1'b0 || data_valid !== 1'b1 || CSB !== 1'b1) bad++;
    end
    chk("hold_single", 32'(bad), 0);
    start = 1'b0;
    do_read($urandom, 4'd2, 1'b0, "second");

    // Reset asserted during bit 10's SCLK high phase.
    @(negedge clk_8M);
    start = 1'b0; mode = 2'b10; TCKHP = 4'd4; q_pat = $urandom; q_idx = 0;
    @(negedge clk_8M) start = 1'b1;
    @(negedge clk_8M) start = 1'b0;
    n = 0;
    while (!(SCLK === 1'b1 && q_idx == 11) && n < 1000) begin
      @(negedge clk_8M);
      n++;
    end
    chk("rst_reach_bit10", 32'(n < 1000), 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_csb", 32'(CSB), 1);
    chk("midrst_sclk", 32'(SCLK), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_data", data_out, 0);
    @(negedge clk_8M) rst = 1'b1;
    do_read(32'h12345678, 4'd4, 1'b0, "after_rst");

    // Randomized reads across the full TCKHP range.
    for (int i = 0; i < 6; i++) begin
      do_read($urandom, 4'($urandom_range(0, 15)), 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
